// File: rtl/accel_pkg.sv
// Shared accelerator types and sizes used by the load path and its memories.
package accel_pkg;

  localparam int VECTOR_WIDTH    = 16;
  localparam int VEC_SLICE_DEPTH = 16;
  localparam int MAT_DEPTH       = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

  typedef enum logic {
    TGT_VECTOR = 1'b0,
    TGT_MATRIX = 1'b1
  } load_target_t;

endpackage

// File: rtl/memory_load_controller_if.sv
// Command, beat-stream and memory-write bundle of the load controller.
interface memory_load_controller_if #(
  parameter int VECTOR_WIDTH = accel_pkg::VECTOR_WIDTH
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_target;
  logic [1:0]              cmd_unit_id;
  logic [7:0]              cmd_base;
  logic [8:0]              cmd_count;
  logic                    cmd_error;
  logic                    s_valid;
  logic                    s_ready;
  logic [VECTOR_WIDTH-1:0] s_data;
  logic [5:0]              addr_a;
  logic                    we_a;
  logic [VECTOR_WIDTH-1:0] data_in_a;
  logic [7:0]              addr_b;
  logic                    we_b;
  logic [1:0]              data_in_b;
  logic                    done;

  modport slave (
    input  cmd_valid, cmd_target, cmd_unit_id, cmd_base, cmd_count,
    input  s_valid, s_data,
    output cmd_ready, cmd_error, s_ready,
    output addr_a, we_a, data_in_a, addr_b, we_b, data_in_b, done
  );

  modport master (
    output cmd_valid, cmd_target, cmd_unit_id, cmd_base, cmd_count,
    output s_valid, s_data,
    input  cmd_ready, cmd_error, s_ready,
    input  addr_a, we_a, data_in_a, addr_b, we_b, data_in_b, done
  );
endinterface

// File: rtl/memory_address_generator.sv
// Forms vector-slice and matrix addresses from unit/row/column indices.
module memory_address_generator (
  input  logic [1:0] unit_id,
  input  logic [3:0] vec_idx,
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [5:0] vec_addr,
  output logic [7:0] mat_addr
);
  assign vec_addr = {unit_id, vec_idx};
  assign mat_addr = {row, col};
endmodule

// File: rtl/memory_load_controller.sv
// Turns a load command plus a beat stream into one registered write per beat
// on the vector (port A) or matrix (port B) memory.
module memory_load_controller
  import accel_pkg::*;
#(
  parameter int VECTOR_WIDTH = accel_pkg::VECTOR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  memory_load_controller_if.slave   io
);

  load_state_t             state_q, state_d;
  load_target_t            tgt_q, tgt_d;
  logic [1:0]              unit_q, unit_d;
  logic [7:0]              idx_q, idx_d;
  logic [8:0]              remaining_q, remaining_d;
  logic [5:0]              addr_a_q, addr_a_d;
  logic                    we_a_q, we_a_d;
  logic [VECTOR_WIDTH-1:0] data_in_a_q, data_in_a_d;
  logic [7:0]              addr_b_q, addr_b_d;
  logic                    we_b_q, we_b_d;
  logic [1:0]              data_in_b_q, data_in_b_d;
  logic                    done_q, done_d;
  logic                    cmd_error_q, cmd_error_d;

  logic [5:0] vec_addr;
  logic [7:0] mat_addr;
  logic       cmd_legal;

  memory_address_generator u_addr_gen (
    .unit_id  (unit_q),
    .vec_idx  (idx_q[3:0]),
    .row      (idx_q[7:4]),
    .col      (idx_q[3:0]),
    .vec_addr (vec_addr),
    .mat_addr (mat_addr)
  );

  // Vector loads may not leave their 16-entry slice; matrix loads may cover it all.
  assign cmd_legal = (io.cmd_count != 9'd0) && (io.cmd_count <= 9'(MAT_DEPTH)) &&
                     !((io.cmd_target == TGT_VECTOR) && (io.cmd_count > 9'(VEC_SLICE_DEPTH)));

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    tgt_d       = tgt_q;
    unit_d      = unit_q;
    idx_d       = idx_q;
    remaining_d = remaining_q;
    addr_a_d    = addr_a_q;
    data_in_a_d = data_in_a_q;
    addr_b_d    = addr_b_q;
    data_in_b_d = data_in_b_q;
    we_a_d      = 1'b0;
    we_b_d      = 1'b0;
    done_d      = 1'b0;
    cmd_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (io.cmd_valid) begin
          if (cmd_legal) begin
            tgt_d       = load_target_t'(io.cmd_target);
            unit_d      = io.cmd_unit_id;
            idx_d       = io.cmd_base;
            remaining_d = io.cmd_count;
            state_d     = LOAD;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (io.s_valid) begin
          if (tgt_q == TGT_VECTOR) begin
            we_a_d      = 1'b1;
            addr_a_d    = vec_addr;
            data_in_a_d = io.s_data;
            idx_d       = {idx_q[7:4], idx_q[3:0] + 4'd1};
          end else begin
            we_b_d      = 1'b1;
            addr_b_d    = mat_addr;
            data_in_b_d = io.s_data[1:0];
            idx_d       = idx_q + 8'd1;
          end
          remaining_d = remaining_q - 9'd1;
          if (remaining_q == 9'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including address/data holding registers, resets so
  // reset mid-load leaves no stale strobe, count or address behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_q       <= TGT_VECTOR;
      unit_q      <= '0;
      idx_q       <= '0;
      remaining_q <= '0;
      addr_a_q    <= '0;
      we_a_q      <= 1'b0;
      data_in_a_q <= '0;
      addr_b_q    <= '0;
      we_b_q      <= 1'b0;
      data_in_b_q <= '0;
      done_q      <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      unit_q      <= unit_d;
      idx_q       <= idx_d;
      remaining_q <= remaining_d;
      addr_a_q    <= addr_a_d;
      we_a_q      <= we_a_d;
      data_in_a_q <= data_in_a_d;
      addr_b_q    <= addr_b_d;
      we_b_q      <= we_b_d;
      data_in_b_q <= data_in_b_d;
      done_q      <= done_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign io.cmd_ready = (state_q == IDLE);
  assign io.s_ready   = (state_q == LOAD);
  assign io.cmd_error = cmd_error_q;
  assign io.addr_a    = addr_a_q;
  assign io.we_a      = we_a_q;
  assign io.data_in_a = data_in_a_q;
  assign io.addr_b    = addr_b_q;
  assign io.we_b      = we_b_q;
  assign io.data_in_b = data_in_b_q;
  assign io.done      = done_q;

endmodule

// File: tb/tb_memory_load_controller.sv
// Directed bench for memory_load_controller: vector/matrix loads, wrap,
// illegal commands, bubbles and reset in the middle of a load.
module tb_memory_load_controller;
  import accel_pkg::*;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miscmp;

  memory_load_controller_if #(.VECTOR_WIDTH(VECTOR_WIDTH)) bus ();

  memory_load_controller #(.VECTOR_WIDTH(VECTOR_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string name);
    vec_cnt++;
    if (bus.we_a !== 1'b0 || bus.we_b !== 1'b0 || bus.done !== 1'b0 ||
        bus.cmd_ready !== 1'b1 || bus.s_ready !== 1'b0) begin
      miscmp++;
      $display("FAIL %s idle: we_a=%b we_b=%b done=%b cmd_ready=%b s_ready=%b, wanted 0 0 0 1 0",
               name, bus.we_a, bus.we_b, bus.done, bus.cmd_ready, bus.s_ready);
    end
  endtask

  task automatic issue_cmd(input logic tgt, input logic [1:0] unit,
                           input logic [7:0] base, input logic [8:0] count);
    bus.cmd_valid   = 1'b1;
    bus.cmd_target  = tgt;
    bus.cmd_unit_id = unit;
    bus.cmd_base    = base;
    bus.cmd_count   = count;
    step();
    bus.cmd_valid   = 1'b0;
  endtask

  // Continuous-beat load; expected addresses follow the wrap rules directly.
  task automatic do_load(input logic tgt, input logic [1:0] unit, input logic [7:0] base,
                         input int count, input logic [15:0] seed, input string name);
    logic [5:0]  ea;
    logic [7:0]  eb;
    logic [3:0]  lo;
    logic [15:0] ed;
    issue_cmd(tgt, unit, base, 9'(count));
    vec_cnt++;
    if (bus.s_ready !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      miscmp++;
      $display("FAIL %s accept: s_ready=%b cmd_ready=%b, wanted 1 0", name, bus.s_ready, bus.cmd_ready);
    end
    ea = '0;
    for (int k = 0; k < count; k++) begin
      ed = (tgt == TGT_MATRIX) ? 16'(k % 4) : seed + 16'(k);
      bus.s_valid = 1'b1;
      bus.s_data  = ed;
      step();
      lo = base[3:0] + 4'(k);
      ea = {unit, lo};
      eb = base + 8'(k);
      vec_cnt++;
      if (tgt == TGT_VECTOR) begin
        if (bus.we_a !== 1'b1 || bus.we_b !== 1'b0 || bus.addr_a !== ea || bus.data_in_a !== ed) begin
          miscmp++;
          $display("FAIL %s beat %0d: we_a=%b we_b=%b addr_a=%0d data=%h, wanted 1 0 %0d %h",
                   name, k, bus.we_a, bus.we_b, bus.addr_a, bus.data_in_a, ea, ed);
        end
      end else begin
        if (bus.we_b !== 1'b1 || bus.we_a !== 1'b0 || bus.addr_b !== eb || bus.data_in_b !== ed[1:0]) begin
          miscmp++;
          $display("FAIL %s beat %0d: we_b=%b we_a=%b addr_b=%0d data=%h, wanted 1 0 %0d %h",
                   name, k, bus.we_b, bus.we_a, bus.addr_b, bus.data_in_b, eb, ed[1:0]);
        end
      end
      vec_cnt++;
      if (bus.done !== (k == count - 1) || bus.s_ready !== (k != count - 1)) begin
        miscmp++;
        $display("FAIL %s beat %0d flags: done=%b s_ready=%b, wanted %b %b",
                 name, k, bus.done, bus.s_ready, (k == count - 1), (k != count - 1));
      end
    end
    bus.s_valid = 1'b0;
    step();
    expect_idle(name);
    vec_cnt++;
    if ((tgt == TGT_VECTOR && bus.addr_a !== ea) || (tgt == TGT_MATRIX && bus.addr_b !== eb)) begin
      miscmp++;
      $display("FAIL %s hold: addr_a=%0d addr_b=%0d, wanted last address kept", name, bus.addr_a, bus.addr_b);
    end
  endtask

  task automatic test_reset();
    vec_cnt++;
    if (bus.cmd_ready !== 1'b1 || bus.s_ready !== 1'b0 || bus.we_a !== 1'b0 || bus.we_b !== 1'b0 ||
        bus.addr_a !== 6'd0 || bus.addr_b !== 8'd0 || bus.data_in_a !== '0 || bus.data_in_b !== 2'd0 ||
        bus.done !== 1'b0 || bus.cmd_error !== 1'b0) begin
      miscmp++;
      $display("FAIL reset: cmd_ready=%b s_ready=%b we_a=%b we_b=%b addr_a=%0d addr_b=%0d done=%b err=%b, wanted 1 then all 0",
               bus.cmd_ready, bus.s_ready, bus.we_a, bus.we_b, bus.addr_a, bus.addr_b, bus.done, bus.cmd_error);
    end
  endtask

  task automatic test_vector_wrap();
    do_load(TGT_VECTOR, 2'd2, 8'd14, 4, 16'h000A, "vec_wrap");
  endtask

  task automatic test_full_matrix();
    do_load(TGT_MATRIX, 2'd0, 8'd0, 256, 16'h0000, "mat_full");
  endtask

  task automatic test_matrix_wrap();
    do_load(TGT_MATRIX, 2'd1, 8'hFE, 3, 16'h0000, "mat_wrap");
  endtask

  task automatic test_illegal();
    logic        tgts [3] = '{TGT_MATRIX, TGT_VECTOR, TGT_MATRIX};
    logic [8:0]  cnts [3] = '{9'd0, 9'd17, 9'd257};
    for (int i = 0; i < 3; i++) begin
      issue_cmd(tgts[i], 2'd0, 8'd0, cnts[i]);
      vec_cnt++;
      if (bus.cmd_error !== 1'b1) begin
        miscmp++;
        $display("FAIL illegal %0d pulse: cmd_error=%b, wanted 1", i, bus.cmd_error);
      end
      expect_idle("illegal");
      step();
      vec_cnt++;
      if (bus.cmd_error !== 1'b0) begin
        miscmp++;
        $display("FAIL illegal %0d width: cmd_error=%b, wanted 0", i, bus.cmd_error);
      end
      expect_idle("illegal_after");
    end
  endtask

  task automatic test_bubbles();
    logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   beats;
    beats = 0;
    issue_cmd(TGT_VECTOR, 2'd1, 8'd0, 9'd3);
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = pat[i];
      bus.s_data  = 16'h0100 + 16'(i);
      step();
      if (pat[i]) beats++;
      vec_cnt++;
      if (bus.we_a !== pat[i] || bus.done !== (beats == 3 && pat[i]) || bus.s_ready !== (beats < 3)) begin
        miscmp++;
        $display("FAIL bubble cycle %0d: we_a=%b done=%b s_ready=%b, wanted %b %b %b",
                 i, bus.we_a, bus.done, bus.s_ready, pat[i], (beats == 3 && pat[i]), (beats < 3));
      end
      if (pat[i]) begin
        vec_cnt++;
        if (bus.addr_a !== 6'(16 + beats - 1) || bus.data_in_a !== 16'h0100 + 16'(i)) begin
          miscmp++;
          $display("FAIL bubble beat %0d: addr_a=%0d data=%h, wanted %0d %h",
                   beats, bus.addr_a, bus.data_in_a, 16 + beats - 1, 16'h0100 + 16'(i));
        end
      end
    end
    bus.s_valid = 1'b0;
    step();
    expect_idle("bubble_end");
  endtask

  task automatic test_reset_mid_load();
    issue_cmd(TGT_VECTOR, 2'd3, 8'd0, 9'd10);
    for (int k = 0; k < 5; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h0200 + 16'(k);
      step();
    end
    vec_cnt++;
    if (bus.we_a !== 1'b1 || bus.addr_a !== 6'd52) begin
      miscmp++;
      $display("FAIL midload pre: we_a=%b addr_a=%0d, wanted 1 52", bus.we_a, bus.addr_a);
    end
    #1 rst_n = 1'b0;
    #1;
    expect_idle("midload_rst");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_idle("midload_after");
    end
    bus.s_valid = 1'b0;
    do_load(TGT_VECTOR, 2'd0, 8'd5, 2, 16'h0055, "post_rst");
  endtask

  initial begin
    vec_cnt         = 0;
    miscmp          = 0;
    rst_n           = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_target  = 1'b0;
    bus.cmd_unit_id = 2'd0;
    bus.cmd_base    = 8'd0;
    bus.cmd_count   = 9'd0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_vector_wrap();
    test_full_matrix();
    test_matrix_wrap();
    test_illegal();
    test_bubbles();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/memory_load_controller.md
# memory_load_controller

Upstream feeder for `shared_memory_unit`. It accepts a load command plus a stream of data beats over a valid/ready handshake. For each beat it generates the target address and drives exactly one registered write strobe on vector port A or matrix port B. Vector loads stay inside one unit's 16-entry slice; matrix loads walk the 256-entry 16x16 matrix linearly.

## Interface
- `VECTOR_WIDTH`, default from `accel_pkg`: width of a vector word and of `s_data`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_target`  in  1  destination: 0 = vector memory, 1 = matrix memory.
- `cmd_unit_id`  in  2  vector unit slice; ignored for matrix loads.
- `cmd_base`  in  8  start index; vector loads use `[3:0]`, matrix loads use all 8 bits as `{row,col}`.
- `cmd_count`  in  9  number of beats, 1..256.
- `cmd_error`  out  1  one-cycle pulse when an illegal command is rejected.
- `s_valid`  in  1  data beat offered.
- `s_ready`  out  1  beat accepted when high with `s_valid`.
- `s_data`  in  VECTOR_WIDTH  beat payload; matrix loads use `[1:0]`.
- `addr_a`  out  6  vector address.
- `we_a`  out  1  vector write strobe.
- `data_in_a`  out  VECTOR_WIDTH  vector write data.
- `addr_b`  out  8  matrix address.
- `we_b`  out  1  matrix write strobe.
- `data_in_b`  out  2  matrix write data.
- `done`  out  1  one-cycle pulse after the final write.

## Operation
- **States:** IDLE, LOAD, DONE.
- **IDLE**
  - `cmd_ready`=1 and `s_ready`=0.
  - On a command handshake, the fields are latched and legality is checked.
  - A command is illegal when `cmd_count`==0, when `cmd_count`>256, or when `cmd_target`=0 and `cmd_count`>16.
  - Illegal command: `cmd_error` pulses on the next cycle, no write is issued, and the FSM stays in IDLE.
  - Legal command: go to LOAD, with `remaining` = `cmd_count` and `idx` = `cmd_base`.
- **LOAD**
  - `cmd_ready`=0 and `s_ready`=1. Incoming commands are held off.
  - Each beat handshake registers one write on the next cycle:
    - vector target: `we_a`=1, `addr_a` = {unit_id, idx[3:0]}, `data_in_a` = `s_data`;
    - matrix target: `we_b`=1, `addr_b` = idx[7:0], `data_in_b` = `s_data[1:0]`.
  - After each beat, `idx` and `remaining` are updated:
    - vector target: `idx[3:0]` increments modulo 16, so base 14 with count 4 writes 14, 15, 0, 1 of the same unit;
    - matrix target: `idx` increments modulo 256;
    - `remaining` decrements by 1.
  - When the beat that takes `remaining` from 1 to 0 is accepted, the FSM goes to DONE. `s_ready` drops in the same cycle the FSM enters DONE.
  - While `s_valid`=0 the FSM waits indefinitely and no strobe is issued.
- **DONE**
  - `done`=1 for one cycle, coinciding with the final write strobe.
  - Then return to IDLE.
- **Write strobes**
  - `we_a` and `we_b` are never high together.
  - Each strobe is high for exactly one cycle per beat.
  - Address and data outputs hold their last value while the strobe is low.
- **Reset**
  - Reset may be asserted at any time, including in the middle of a load.
  - It forces IDLE, discards the command and any partially loaded count, and clears all strobes.
  - Writes already issued are not undone.

## Timing
- **Reset values:** `cmd_ready`=1 (combinational from the state, so 1 in IDLE), and 0 for `s_ready`, `we_a`, `we_b`, `addr_a`, `addr_b`, `data_in_a`, `data_in_b`, `done` and `cmd_error`.
- **Command latency:** the command handshake at cycle C gives `s_ready`=1 at C+1.
- **Write latency:** the beat handshake at cycle N gives its write strobe at N+1.
- **Throughput:** one beat per cycle with `s_valid` held high, so a count-K load completes with `done` at C+1+K.
- **Back-to-back commands:** `cmd_ready` returns to 1 the cycle after `done`.
- **All outputs are registered** except `cmd_ready` and `s_ready`, which are decoded from the state.

## Structure
- **Add to `accel_pkg`:**
  - `load_state_t` enum (IDLE, LOAD, DONE);
  - `load_target_t` (TGT_VECTOR=0, TGT_MATRIX=1);
  - `VEC_SLICE_DEPTH`=16;
  - `MAT_DEPTH`=256.
- **Address formation** reuses the codebase's `memory_address_generator` sub-module, fed with unit_id/idx[3:0] and idx[7:4]/idx[3:0].
- **Everything else** is one module: FSM, counters and output registers.

## Test plan
- **Vector load with wrap:** unit 2, base 14, count 4, beats 0xA..0xD -> `we_a` on 4 consecutive cycles at `addr_a` 46, 47, 32, 33 with those data; `done` on the 4th strobe.
- **Full matrix load:** base 0, count 256, beat k = k%4 -> 256 `we_b` strobes at addresses 0..255; `we_a` never high; `done` at C+257.
- **Matrix wrap:** base 0xFE, count 3 -> `addr_b` 0xFE, 0xFF, 0x00.
- **Illegal commands:** count 0, and vector count 17 -> `cmd_error` pulse each time, no strobes, `cmd_ready` stays 1.
- **Bubbles:** `s_valid` toggling 1,0,0,1,1 during a count-3 load -> exactly 3 strobes, each one cycle after its handshake.
- **Reset mid-load:** `rst_n` low after 5 of 10 beats -> strobes cleared immediately, IDLE, `done` never asserted; a new count-2 command then completes normally.
